// File: rtl/gcd_pkg.sv
// gcd_pkg: ALU operation codes and controller state encoding shared by the GCD block.
package gcd_pkg;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_MAX = 3'd1;
  localparam logic [2:0] ALU_MIN = 3'd2;
  localparam logic [2:0] ALU_MOD = 3'd3;
  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    ORD_MAX,
    WB_GROSS,
    ORD_MIN,
    WB_KLEIN,
    SWAP,
    MOD_START,
    MOD_WAIT,
    MOD_WB,
    CHECK,
    SHIFT,
    NEWNUM,
    DONE,
    ABORT
  } state_t;
endpackage

// File: rtl/gcd_controller.sv
// gcd_controller: Moore FSM sequencing the GCD datapath through Euclid's algorithm,
// with an iteration limit and a modulo watchdog so stalled runs end in an error pulse.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER    = 32,
  parameter int MOD_TIMEOUT = 64,
  parameter int ITER_W      = 6
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              modulo_ready_i,
  input  logic              valid_i,
  output logic [2:0]        alu_mode_o,
  output logic              modulo_start_o,
  output logic              wren_initial_o,
  output logic              wren_zw_gross_o,
  output logic              wren_zw_klein_o,
  output logic              wren_zw_in_zahlen_o,
  output logic              wren_erg_modulo_o,
  output logic              wren_Zahl_o,
  output logic              wren_to_new_numbers_o,
  output logic              Zahl1_to_alu_a_o,
  output logic              Zahl2_to_alu_b_o,
  output logic              check_for_termination_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ITER_W-1:0] iter_o
);
  localparam int WD_W = $clog2(MOD_TIMEOUT + 1);
  state_t state, next;
  logic [WD_W-1:0] wd;
  logic operands;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      iter_o <= '0;
      wd     <= '0;
    end else begin
      state  <= next;
      iter_o <= state == LOAD ? '0 : state == MOD_WB ? iter_o + 1'b1 : iter_o;
      wd     <= state == MOD_START ? '0 : state == MOD_WAIT ? wd + 1'b1 : wd;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = start_i ? LOAD : IDLE;
      LOAD:      next = ORD_MAX;
      ORD_MAX:   next = WB_GROSS;
      WB_GROSS:  next = ORD_MIN;
      ORD_MIN:   next = WB_KLEIN;
      WB_KLEIN:  next = SWAP;
      SWAP:      next = MOD_START;
      MOD_START: next = MOD_WAIT;
      // a ready in the final watchdog cycle still completes the iteration
      MOD_WAIT:  next = modulo_ready_i ? MOD_WB : wd == WD_W'(MOD_TIMEOUT - 1) ? ABORT : MOD_WAIT;
      MOD_WB:    next = CHECK;
      CHECK:     next = valid_i ? DONE : iter_o == ITER_W'(MAX_ITER) ? ABORT : SHIFT;
      SHIFT:     next = NEWNUM;
      NEWNUM:    next = MOD_START;
      default:   next = IDLE;
    endcase
  end
  assign operands = state == ORD_MAX || state == ORD_MIN || state == MOD_START || state == MOD_WAIT;
  assign alu_mode_o = state == ORD_MAX ? ALU_MAX : state == ORD_MIN ? ALU_MIN :
                      (state == MOD_START || state == MOD_WAIT) ? ALU_MOD : ALU_NOP;
  assign Zahl1_to_alu_a_o        = operands;
  assign Zahl2_to_alu_b_o        = operands;
  assign modulo_start_o          = state == MOD_START;
  assign wren_initial_o          = state == LOAD;
  assign wren_zw_gross_o         = state == WB_GROSS;
  assign wren_zw_klein_o         = state == WB_KLEIN;
  assign wren_zw_in_zahlen_o     = state == SWAP;
  assign wren_erg_modulo_o       = state == MOD_WB;
  assign wren_Zahl_o             = state == SHIFT;
  assign wren_to_new_numbers_o   = state == NEWNUM;
  assign check_for_termination_o = state == CHECK;
  assign busy_o                  = state != IDLE;
  assign done_o                  = state == DONE;
  assign error_o                 = state == ABORT;
endmodule
